count_sequencer: RTL and testbench
==================================

Name: count_sequencer

Overview:
- Controller that sequences a WIDTH-bit counter datapath.
- Accepts a start command with shadowed configuration: limit, direction, auto-reload and prescale divisor.
- Generates the counter enable internally from a prescaler, and reports busy/done/wrap status.
- Sits between software-visible control logic and the count display/consumer.

Parameters:
WIDTH, 8, counter width
PRESCALE_W, 16, prescaler divisor width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  launch sequence (sampled in IDLE only)
abort  input  1  cancel active sequence
pause  input  1  level; freeze counting while high
dir  input  1  0 = count up 0→limit, 1 = count down limit→0
reload  input  1  1 = auto-reload at terminal, 0 = one-shot
limit  input  WIDTH  terminal (up) or start value (down)
div  input  PRESCALE_W  one tick every div+1 cycles
count  output  WIDTH  current count
busy  output  1  high in RUN and PAUSED
done  output  1  one-cycle pulse on one-shot completion
wrap  output  1  one-cycle pulse on each auto-reload
state  output  2  IDLE=0, RUN=1, PAUSED=2, DONE=3

Behaviour:
- Reset values:
  - count=0, busy=0, done=0, wrap=0, state=IDLE.
  - Prescaler and all shadow registers = 0.
- Priority, highest first: rst > abort > start > pause > tick.
- IDLE:
  - On start=1 (with abort=0), latch limit/dir/reload/div into shadows.
  - Same edge: count <= (dir ? limit : 0), prescaler <= 0, state <= RUN.
  - Consequently busy=1 and count is preset one cycle after start is sampled.
  - abort is ignored in IDLE. start together with abort is dropped.
- RUN:
  - Prescaler increments each cycle.
  - tick = (prescaler == div_s). On a tick, prescaler <= 0.
  - On a tick with count != terminal (limit_s if up, 0 if down): count steps ±1.
  - On a tick with count == terminal:
    - reload_s=1: count <= start value, wrap=1 next cycle, stay RUN.
    - reload_s=0: state <= DONE, count holds terminal.
  - Timing: for a start sampled at edge E0, the terminal event occurs at edge E0+(L+1)(D+1), where L = span and D = div_s.
- PAUSED:
  - Entered on the edge where pause=1 in RUN. If a tick coincides, pause wins: no step, prescaler frozen.
  - count and prescaler hold.
  - Returns to RUN on the first edge with pause=0, then resumes from the frozen prescaler value.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0. Next state is IDLE.
  - start during DONE is ignored.
- abort in RUN/PAUSED:
  - state <= IDLE next edge, busy=0, count holds its last value.
  - No done or wrap pulse.
- Boundary conditions:
  - limit=0: terminal event on the first tick.
  - div=0: tick every cycle.
  - Counter arithmetic never wraps modulo 2^WIDTH (a terminal is always reached first).
  - Input changes while busy have no effect (shadowed).
  - start while busy is ignored.
  - rst mid-run returns all state to reset values on that edge.

Optional Feature:
- Macro COUNT_SEQ_STICKY_IRQ_EN.
- When defined:
  - Adds input irq_clr (1) and output irq (1).
  - irq is set on the cycle done or wrap pulses and holds until irq_clr=1.
  - Set wins over a simultaneous clear.
  - rst clears irq.
- When undefined: ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst 2 cycles mid-RUN → count=0, busy=0, state=IDLE, done=0, wrap=0.
- Up one-shot: limit=3, div=2, dir=0, reload=0, start → count 0,1,2,3 each held 3 cycles; done pulses 1 cycle, 12 cycles after the start edge; then IDLE with count=3.
- Down auto-reload: limit=2, div=0, dir=1, reload=1 → count 2,1,0,2,1,0…; wrap pulses every 3 cycles; done never asserts; busy stays 1.
- Pause/abort: up with limit=10, div=0; pause for 5 cycles at count=4 → count holds 4, state=PAUSED; release → resumes at 5; abort at count=7 → IDLE, count=7, no done.
- Corners: limit=0, div=0, one-shot → done 1 cycle after entering RUN. Separately, change limit/div mid-run → no effect; start while busy → ignored; start+abort in IDLE → stays IDLE.
- Feature on: done sets irq; irq held 10 cycles; irq_clr coincident with a wrap pulse → irq stays 1; a later irq_clr alone → irq=0.

Source files
------------

// File: rtl/count_sequencer.sv
// count_sequencer
//   Sequences a WIDTH-bit up/down counter. A start command in IDLE captures
//   limit/dir/reload/div into shadow registers. After that the sequence runs
//   from the shadows only, so changes on the live inputs do not affect it.
//   An internal prescaler produces one count tick every div+1 cycles.
//
//   Optional build macro: COUNT_SEQ_STICKY_IRQ_EN
//     Adds irq_clr/irq. irq is a sticky flag that is set by done or wrap and
//     cleared by irq_clr. If set and clear occur together, set wins.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    launch a sequence (IDLE only; dropped if abort is also high)
//   abort    cancel an active sequence (RUN/PAUSED), count holds
//   pause    level; freezes counter and prescaler while high
//   dir      0 = up 0->limit, 1 = down limit->0
//   reload   1 = auto-reload at terminal, 0 = one-shot
//   limit    terminal (up) or start value (down)
//   div      tick period minus one
//   count    current count
//   busy     high in RUN and PAUSED
//   done     one-cycle pulse (DONE state) on one-shot completion
//   wrap     one-cycle pulse after each auto-reload
//   state    IDLE=0, RUN=1, PAUSED=2, DONE=3
//   irq_clr  (optional) clear sticky irq
//   irq      (optional) sticky interrupt flag
module count_sequencer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pause,
  input  logic                  dir,
  input  logic                  reload,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] div,
`ifdef COUNT_SEQ_STICKY_IRQ_EN
  input  logic                  irq_clr,
  output logic                  irq,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_W-1:0] pscl_q, pscl_d;
  logic                  wrap_q, wrap_d;
  logic                  load_shadow;

  logic [WIDTH-1:0]      limit_s;
  logic [PRESCALE_W-1:0] div_s;
  logic                  dir_s;
  logic                  reload_s;

  logic                  tick;
  logic                  terminal;

  assign tick     = (pscl_q == div_s);
  // Terminal value depends on direction: limit when counting up, zero when down.
  assign terminal = dir_s ? (count_q == '0) : (count_q == limit_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      pscl_q   <= '0;
      wrap_q   <= 1'b0;
      limit_s  <= '0;
      div_s    <= '0;
      dir_s    <= 1'b0;
      reload_s <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pscl_q  <= pscl_d;
      wrap_q  <= wrap_d;
      if (load_shadow) begin
        limit_s  <= limit;
        div_s    <= div;
        dir_s    <= dir;
        reload_s <= reload;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pscl_d      = pscl_q;
    wrap_d      = 1'b0;
    load_shadow = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // abort has no meaning in IDLE except to suppress a coincident start.
        if (start && !abort) begin
          load_shadow = 1'b1;
          count_d     = dir ? limit : '0;
          pscl_d      = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (pause) begin
          // Pause beats a coincident tick: prescaler and count both freeze.
          state_d = S_PAUSED;
        end else if (tick) begin
          pscl_d = '0;
          if (!terminal) begin
            count_d = dir_s ? (count_q - 1'b1) : (count_q + 1'b1);
          end else if (reload_s) begin
            count_d = dir_s ? limit_s : '0;
            wrap_d  = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          pscl_d = pscl_q + 1'b1;
        end
      end
      S_PAUSED: begin
        // The release edge itself does not advance the prescaler.
        if (abort) begin
          state_d = S_IDLE;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign count = count_q;
  assign busy  = (state_q == S_RUN) || (state_q == S_PAUSED);
  assign done  = (state_q == S_DONE);
  assign wrap  = wrap_q;
  assign state = state_q;

`ifdef COUNT_SEQ_STICKY_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (done || wrap) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_count_sequencer.sv
module tb_count_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort, pause, dir, reload;
  logic [7:0]  limit;
  logic [15:0] div;
  logic [7:0]  count;
  logic        busy, done, wrap;
  logic [1:0]  state;
`ifdef COUNT_SEQ_STICKY_IRQ_EN
  logic        irq_clr, irq;
`endif

  int vectors = 0;
  int errors  = 0;

  count_sequencer #(.WIDTH(8), .PRESCALE_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .pause  (pause),
    .dir    (dir),
    .reload (reload),
    .limit  (limit),
    .div    (div),
`ifdef COUNT_SEQ_STICKY_IRQ_EN
    .irq_clr(irq_clr),
    .irq    (irq),
`endif
    .count  (count),
    .busy   (busy),
    .done   (done),
    .wrap   (wrap),
    .state  (state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input logic [7:0] l, input logic [15:0] d,
                        input logic dr, input logic rl);
    limit = l; div = d; dir = dr; reload = rl; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    vectors++;
    if (count !== 8'd0 || busy !== 1'b0 || state !== 2'd0 || done !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: count=%0d busy=%b state=%0d done=%b wrap=%b, required 0/0/0/0/0",
               count, busy, state, done, wrap);
    end
    launch(8'd50, 16'd0, 1'b0, 1'b0);
    step(5);
    vectors++;
    if (count !== 8'd5 || state !== 2'd1) begin
      errors++;
      $display("FAIL reset_prerun: count=%0d state=%0d, required 5/1", count, state);
    end
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    vectors++;
    if (count !== 8'd0 || busy !== 1'b0 || state !== 2'd0 || done !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: count=%0d busy=%b state=%0d done=%b wrap=%b, required 0/0/0/0/0",
               count, busy, state, done, wrap);
    end
  endtask

  // limit=3, div=2: each value held 3 cycles, done during cycle after edge E0+12.
  task automatic test_up_oneshot;
    logic [7:0] exp_cnt;
    launch(8'd3, 16'd2, 1'b0, 1'b0);
    vectors++;
    if (count !== 8'd0 || busy !== 1'b1 || state !== 2'd1) begin
      errors++;
      $display("FAIL up_start: count=%0d busy=%b state=%0d, required 0/1/1", count, busy, state);
    end
    for (int k = 1; k <= 12; k++) begin
      step(1);
      exp_cnt = (k >= 9) ? 8'd3 : 8'(k / 3);
      vectors++;
      if (count !== exp_cnt || done !== (k == 12) || busy !== (k != 12)) begin
        errors++;
        $display("FAIL up_seq k=%0d: count=%0d done=%b busy=%b, required %0d/%b/%b",
                 k, count, done, busy, exp_cnt, (k == 12), (k != 12));
      end
    end
    // start sampled in the DONE cycle must be ignored.
    start = 1'b1;
    step(1);
    start = 1'b0;
    vectors++;
    if (state !== 2'd0 || count !== 8'd3 || done !== 1'b0) begin
      errors++;
      $display("FAIL up_end: state=%0d count=%0d done=%b, required 0/3/0", state, count, done);
    end
  endtask

  task automatic test_down_reload;
    logic [7:0] exp_cnt;
    launch(8'd2, 16'd0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step(1);
      exp_cnt = 8'(2 - (k % 3));
      vectors++;
      if (count !== exp_cnt || wrap !== (k > 0 && k % 3 == 0) || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL down_seq k=%0d: count=%0d wrap=%b done=%b busy=%b, required %0d/%b/0/1",
                 k, count, wrap, done, busy, exp_cnt, (k > 0 && k % 3 == 0));
      end
    end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    vectors++;
    if (state !== 2'd0 || count !== 8'd2 || wrap !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL down_abort: state=%0d count=%0d wrap=%b done=%b, required 0/2/0/0",
               state, count, wrap, done);
    end
  endtask

  task automatic test_pause_abort;
    launch(8'd10, 16'd0, 1'b0, 1'b0);
    step(4);
    vectors++;
    if (count !== 8'd4) begin
      errors++;
      $display("FAIL pa_pre: count=%0d, required 4", count);
    end
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      vectors++;
      if (count !== 8'd4 || state !== 2'd2 || busy !== 1'b1) begin
        errors++;
        $display("FAIL pa_hold k=%0d: count=%0d state=%0d busy=%b, required 4/2/1", k, count, state, busy);
      end
    end
    pause = 1'b0;
    step(1);
    vectors++;
    if (count !== 8'd4 || state !== 2'd1) begin
      errors++;
      $display("FAIL pa_release: count=%0d state=%0d, required 4/1", count, state);
    end
    step(1);
    vectors++;
    if (count !== 8'd5) begin
      errors++;
      $display("FAIL pa_resume: count=%0d, required 5", count);
    end
    step(2);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    vectors++;
    if (state !== 2'd0 || count !== 8'd7 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL pa_abort: state=%0d count=%0d busy=%b done=%b, required 0/7/0/0",
               state, count, busy, done);
    end
    step(1);
    vectors++;
    if (done !== 1'b0 || count !== 8'd7) begin
      errors++;
      $display("FAIL pa_after: done=%b count=%0d, required 0/7", done, count);
    end
  endtask

  task automatic test_corners;
    // limit=0, div=0 one-shot: DONE one cycle after entering RUN.
    launch(8'd0, 16'd0, 1'b0, 1'b0);
    vectors++;
    if (state !== 2'd1 || count !== 8'd0) begin
      errors++;
      $display("FAIL zero_run: state=%0d count=%0d, required 1/0", state, count);
    end
    step(1);
    vectors++;
    if (state !== 2'd3 || done !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: state=%0d done=%b, required 3/1", state, done);
    end
    step(1);
    vectors++;
    if (state !== 2'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: state=%0d done=%b, required 0/0", state, done);
    end
    // Shadowing: limit=2, div=1 up, terminal at E0+6 regardless of input changes.
    launch(8'd2, 16'd1, 1'b0, 1'b0);
    limit = 8'd200; div = 16'd0; dir = 1'b1; reload = 1'b1;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    vectors++;
    if (count !== 8'd1 || state !== 2'd1) begin
      errors++;
      $display("FAIL shadow_mid: count=%0d state=%0d, required 1/1", count, state);
    end
    step(3);
    vectors++;
    if (count !== 8'd2 || state !== 2'd1) begin
      errors++;
      $display("FAIL shadow_hold: count=%0d state=%0d, required 2/1", count, state);
    end
    step(1);
    vectors++;
    if (done !== 1'b1 || count !== 8'd2) begin
      errors++;
      $display("FAIL shadow_done: done=%b count=%0d, required 1/2", done, count);
    end
    step(1);
    // start together with abort in IDLE is dropped.
    start = 1'b1; abort = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    vectors++;
    if (state !== 2'd0 || busy !== 1'b0 || count !== 8'd2) begin
      errors++;
      $display("FAIL start_abort: state=%0d busy=%b count=%0d, required 0/0/2", state, busy, count);
    end
  endtask

`ifdef COUNT_SEQ_STICKY_IRQ_EN
  task automatic test_irq;
    launch(8'd0, 16'd0, 1'b0, 1'b0);
    step(2);
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (irq !== 1'b1) begin
        errors++;
        $display("FAIL irq_hold k=%0d: irq=%b, required 1", k, irq);
      end
      step(1);
    end
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    vectors++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clr1: irq=%b, required 0", irq);
    end
    // limit=1 down reload: wrap visible after edge E0+2.
    launch(8'd1, 16'd0, 1'b1, 1'b1);
    step(2);
    vectors++;
    if (wrap !== 1'b1 || irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_wrap: wrap=%b irq=%b, required 1/0", wrap, irq);
    end
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    vectors++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_setwins: irq=%b, required 1", irq);
    end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    vectors++;
    if (irq !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("FAIL irq_clr2: irq=%b state=%0d, required 0/0", irq, state);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    dir = 1'b0; reload = 1'b0; limit = 8'd0; div = 16'd0;
`ifdef COUNT_SEQ_STICKY_IRQ_EN
    irq_clr = 1'b0;
`endif
    #2;
    test_reset;
    test_up_oneshot;
    test_down_reload;
    test_pause_abort;
    test_corners;
`ifdef COUNT_SEQ_STICKY_IRQ_EN
    test_irq;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
